// File: rtl/fir_coeff_loader.sv
// fir_coeff_loader
// Coefficient bank controller for fir_serial_parallel.
// Coefficients arrive serially over a valid/ready handshake, index 0 first, and
// are collected in a shadow bank. A complete shadow bank is copied to the
// active bank only on a sample-boundary tick. This way the filter never sees a
// partially updated coefficient set.
//
// Ports:
//   i_clock        system clock, rising edge
//   i_reset        asynchronous reset, active low
//   i_wr_valid     coefficient beat valid
//   i_wr_coeff     signed coefficient beat
//   i_wr_last      final beat of a load
//   o_wr_ready     loader can accept a beat (low in ARMED and during reset)
//   i_abort        drop the in-progress or armed load
//   i_sample_tick  filter sample-boundary strobe
//   o_coeffs       active bank, element k = tap k (registered)
//   o_swap         one-cycle pulse, active bank updated this cycle
//   o_armed        complete shadow bank waiting for a tick
//   o_err          sticky length error, cleared by the first beat of a new load
module fir_coeff_loader #(
    parameter int NB_COEFFS = 8,
    parameter int N_COEFFS  = 8
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic                        i_wr_valid,
    input  logic signed [NB_COEFFS-1:0] i_wr_coeff,
    input  logic                        i_wr_last,
    output logic                        o_wr_ready,
    input  logic                        i_abort,
    input  logic                        i_sample_tick,
    output logic signed [NB_COEFFS-1:0] o_coeffs [N_COEFFS],
    output logic                        o_swap,
    output logic                        o_armed,
    output logic                        o_err
);

    localparam int IW = (N_COEFFS > 1) ? $clog2(N_COEFFS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N_COEFFS - 1);

    typedef enum logic [1:0] {IDLE, LOAD, ARMED} state_t;

    state_t                      state_q;
    logic [IW-1:0]               idx_q;
    logic                        ready_q;
    logic                        swap_q;
    logic                        armed_q;
    logic                        err_q;
    logic signed [NB_COEFFS-1:0] shadow_q [N_COEFFS];
    logic signed [NB_COEFFS-1:0] active_q [N_COEFFS];

    logic beat;
    assign beat = i_wr_valid && ready_q;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            ready_q <= 1'b0;
            swap_q  <= 1'b0;
            armed_q <= 1'b0;
            err_q   <= 1'b0;
            for (int k = 0; k < N_COEFFS; k++) begin
                shadow_q[k] <= '0;
                active_q[k] <= '0;
            end
        end else begin
            swap_q  <= 1'b0;
            // ready is low only while a complete bank waits in ARMED
            ready_q <= 1'b1;
            unique case (state_q)
                IDLE: begin
                    // abort has nothing to discard here, so beats proceed
                    if (beat) begin
                        shadow_q[0] <= i_wr_coeff;
                        idx_q       <= IW'(1);
                        if (i_wr_last) begin
                            // single-beat load is always too short (N_COEFFS >= 2)
                            err_q <= 1'b1;
                        end else begin
                            err_q   <= 1'b0;
                            state_q <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (i_abort) begin
                        state_q <= IDLE;
                        idx_q   <= '0;
                    end else if (beat) begin
                        shadow_q[idx_q] <= i_wr_coeff;
                        idx_q           <= idx_q + 1'b1;
                        if (idx_q == LAST_IDX) begin
                            if (i_wr_last) begin
                                state_q <= ARMED;
                                armed_q <= 1'b1;
                                ready_q <= 1'b0;
                            end else begin
                                // long load: the index would run off the bank
                                err_q   <= 1'b1;
                                state_q <= IDLE;
                                idx_q   <= '0;
                            end
                        end else if (i_wr_last) begin
                            // short load: the partial shadow is simply never committed
                            err_q   <= 1'b1;
                            state_q <= IDLE;
                            idx_q   <= '0;
                        end
                    end
                end
                ARMED: begin
                    if (i_abort) begin
                        state_q <= IDLE;
                        idx_q   <= '0;
                        armed_q <= 1'b0;
                    end else if (i_sample_tick) begin
                        active_q <= shadow_q;
                        swap_q   <= 1'b1;
                        armed_q  <= 1'b0;
                        state_q  <= IDLE;
                        idx_q    <= '0;
                    end else begin
                        ready_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    idx_q   <= '0;
                    armed_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_wr_ready = ready_q;
    assign o_coeffs   = active_q;
    assign o_swap     = swap_q;
    assign o_armed    = armed_q;
    assign o_err      = err_q;

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Self-checking bench for fir_coeff_loader: directed scenarios against
// constants plus a randomized run against a queue-based reference model.
module tb_fir_coeff_loader;
    localparam int NB = 8;
    localparam int N  = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic valid = 1'b0, last = 1'b0, abort_s = 1'b0, tick = 1'b0;
    logic signed [NB-1:0] coeff = '0;
    logic ready, swap, armed, err;
    logic signed [NB-1:0] coeffs [N];

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: a load is a queue of beats; it completes when the
    // queue holds exactly N beats and the N-th carries last
    logic signed [NB-1:0] m_active [N];
    logic signed [NB-1:0] m_buf [$];
    bit m_armed, m_err, m_ready, m_swap;

    // -7,-14,20,56,56,20,-14,-7
    logic signed [NB-1:0] gold [N] = '{8'shF9, 8'shF2, 8'sh14, 8'sh38, 8'sh38, 8'sh14, 8'shF2, 8'shF9};
    logic signed [NB-1:0] vals [N];
    logic signed [NB-1:0] prev [N];

    always #5 clk = ~clk;

    fir_coeff_loader #(.NB_COEFFS(NB), .N_COEFFS(N)) dut (
        .i_clock(clk), .i_reset(rst_n),
        .i_wr_valid(valid), .i_wr_coeff(coeff), .i_wr_last(last), .o_wr_ready(ready),
        .i_abort(abort_s), .i_sample_tick(tick),
        .o_coeffs(coeffs), .o_swap(swap), .o_armed(armed), .o_err(err)
    );

    task automatic model_reset();
        m_buf.delete();
        m_armed = 0; m_err = 0; m_ready = 0; m_swap = 0;
        for (int k = 0; k < N; k++) m_active[k] = '0;
    endtask

    task automatic model_edge();
        bit beat;
        beat = valid && m_ready;
        m_swap = 0;
        if (m_armed) begin
            if (abort_s) begin
                m_armed = 0; m_buf.delete();
            end else if (tick) begin
                for (int k = 0; k < N; k++) m_active[k] = m_buf[k];
                m_swap = 1; m_armed = 0; m_buf.delete();
            end
        end else if (abort_s && m_buf.size() != 0) begin
            m_buf.delete();
        end else if (beat) begin
            if (m_buf.size() == 0) m_err = 0;
            m_buf.push_back(coeff);
            if (m_buf.size() == N) begin
                if (last) m_armed = 1;
                else begin m_err = 1; m_buf.delete(); end
            end else if (last) begin
                m_err = 1; m_buf.delete();
            end
        end
        m_ready = !m_armed;
    endtask

    // one clock: drive inputs, take the edge, sample 1 time unit later
    task automatic step(input bit v, input logic signed [NB-1:0] c, input bit l, input bit a, input bit t);
        valid = v; coeff = c; last = l; abort_s = a; tick = t;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic load_bank(input logic signed [NB-1:0] b [N], input bit tick_on_last);
        for (int k = 0; k < N; k++) step(1, b[k], k == N-1, 0, tick_on_last && (k == N-1));
        step(0, '0, 0, 0, 0);
    endtask

    task automatic rand_bank();
        for (int k = 0; k < N; k++) vals[k] = NB'($urandom);
    endtask

    task automatic test_reset();
        model_reset();
        #1;
        if (ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", ready); end
        if ({swap, armed, err} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b want 000", {swap, armed, err}); end
        for (int k = 0; k < N; k++)
            if (coeffs[k] !== '0) begin n_bad++; $display("FAIL reset_coeff[%0d]: got %0d want 0", k, coeffs[k]); end
        n_cmp += 3;
        #11 rst_n = 1'b1;
        step(0, '0, 0, 0, 0);
        n_cmp++;
        if (ready !== 1'b1) begin n_bad++; $display("FAIL ready_after_reset: got %b want 1", ready); end
    endtask

    task automatic test_golden_load();
        load_bank(gold, 0);
        n_cmp++;
        if (armed !== 1'b1) begin n_bad++; $display("FAIL golden_armed: got %b want 1", armed); end
        for (int c = 0; c < 2; c++) begin
            step(0, '0, 0, 0, 0);
            n_cmp++;
            if (armed !== 1'b1 || swap !== 1'b0) begin n_bad++; $display("FAIL golden_wait: got armed=%b swap=%b want 1 0", armed, swap); end
        end
        step(0, '0, 0, 0, 1);
        n_cmp += 2;
        if (swap !== 1'b1 || armed !== 1'b0) begin n_bad++; $display("FAIL golden_swap: got swap=%b armed=%b want 1 0", swap, armed); end
        for (int k = 0; k < N; k++)
            if (coeffs[k] !== gold[k]) begin n_bad++; $display("FAIL golden_coeff[%0d]: got %0d want %0d", k, coeffs[k], gold[k]); end
        step(0, '0, 0, 0, 0);
        n_cmp++;
        if (swap !== 1'b0) begin n_bad++; $display("FAIL golden_swap_pulse: got %b want 0", swap); end
    endtask

    task automatic test_short_load();
        rand_bank();
        for (int k = 0; k < 5; k++) begin
            step(1, vals[k], k == 4, 0, 1);
            if (swap !== 1'b0) begin n_bad++; $display("FAIL short_swap: got %b want 0", swap); end
            n_cmp++;
        end
        n_cmp += 2;
        if (err !== 1'b1 || armed !== 1'b0 || ready !== 1'b1) begin n_bad++; $display("FAIL short_err: got err=%b armed=%b ready=%b want 1 0 1", err, armed, ready); end
        for (int k = 0; k < N; k++)
            if (coeffs[k] !== gold[k]) begin n_bad++; $display("FAIL short_coeff[%0d]: got %0d want %0d", k, coeffs[k], gold[k]); end
    endtask

    task automatic test_abort_armed();
        rand_bank();
        step(1, vals[0], 0, 0, 0);
        n_cmp++;
        if (err !== 1'b0) begin n_bad++; $display("FAIL err_clear: got %b want 0", err); end
        for (int k = 1; k < N; k++) step(1, vals[k], k == N-1, 0, 0);
        n_cmp++;
        if (armed !== 1'b1) begin n_bad++; $display("FAIL abort_armed_pre: got %b want 1", armed); end
        step(0, '0, 0, 1, 0);
        n_cmp++;
        if (armed !== 1'b0 || ready !== 1'b1) begin n_bad++; $display("FAIL abort_armed: got armed=%b ready=%b want 0 1", armed, ready); end
        step(0, '0, 0, 0, 1);
        n_cmp += 2;
        if (swap !== 1'b0) begin n_bad++; $display("FAIL abort_swap: got %b want 0", swap); end
        for (int k = 0; k < N; k++)
            if (coeffs[k] !== gold[k]) begin n_bad++; $display("FAIL abort_coeff[%0d]: got %0d want %0d", k, coeffs[k], gold[k]); end
    endtask

    task automatic test_tick_with_last();
        rand_bank();
        for (int k = 0; k < N; k++) step(1, vals[k], k == N-1, 0, k == N-1);
        n_cmp++;
        if (swap !== 1'b0 || armed !== 1'b1) begin n_bad++; $display("FAIL tick_last: got swap=%b armed=%b want 0 1", swap, armed); end
        for (int c = 0; c < 9; c++) step(0, '0, 0, 0, 0);
        n_cmp++;
        if (coeffs[0] !== gold[0] || armed !== 1'b1) begin n_bad++; $display("FAIL tick_last_hold: got c0=%0d armed=%b want %0d 1", coeffs[0], armed, gold[0]); end
        step(0, '0, 0, 0, 1);
        n_cmp += 2;
        if (swap !== 1'b1) begin n_bad++; $display("FAIL tick_late_swap: got %b want 1", swap); end
        for (int k = 0; k < N; k++)
            if (coeffs[k] !== vals[k]) begin n_bad++; $display("FAIL tick_late_coeff[%0d]: got %0d want %0d", k, coeffs[k], vals[k]); end
        step(0, '0, 0, 0, 0);
    endtask

    task automatic test_backpressure();
        logic signed [NB-1:0] held;
        rand_bank();
        held = NB'($urandom);
        for (int k = 0; k < N; k++) step(1, vals[k], k == N-1, 0, 0);
        for (int c = 0; c < 3; c++) begin
            step(1, held, 0, 0, 0);
            n_cmp++;
            if (ready !== 1'b0 || armed !== 1'b1) begin n_bad++; $display("FAIL bp_armed: got ready=%b armed=%b want 0 1", ready, armed); end
        end
        step(1, held, 0, 0, 1);           // swap; held beat not taken
        n_cmp++;
        if (swap !== 1'b1 || ready !== 1'b1) begin n_bad++; $display("FAIL bp_swap: got swap=%b ready=%b want 1 1", swap, ready); end
        prev = vals;
        vals[0] = held;
        for (int k = 1; k < N; k++) vals[k] = NB'($urandom);
        for (int k = 0; k < N; k++) step(1, vals[k], k == N-1, 0, 0);
        n_cmp++;
        if (armed !== 1'b1 || err !== 1'b0) begin n_bad++; $display("FAIL bp_reload: got armed=%b err=%b want 1 0", armed, err); end
        step(0, '0, 0, 0, 1);
        n_cmp++;
        for (int k = 0; k < N; k++)
            if (coeffs[k] !== vals[k]) begin n_bad++; $display("FAIL bp_coeff[%0d]: got %0d want %0d", k, coeffs[k], vals[k]); end
    endtask

    task automatic test_async_reset();
        rand_bank();
        for (int k = 0; k < 4; k++) step(1, vals[k], 0, 0, 0);
        valid = 1'b0;
        #2 rst_n = 1'b0;                  // between edges
        model_reset();
        #1;
        n_cmp += 2;
        if ({ready, swap, armed, err} !== 4'b0000) begin n_bad++; $display("FAIL async_flags: got %b want 0000", {ready, swap, armed, err}); end
        for (int k = 0; k < N; k++)
            if (coeffs[k] !== '0) begin n_bad++; $display("FAIL async_coeff[%0d]: got %0d want 0", k, coeffs[k]); end
        #4 rst_n = 1'b1;
        step(0, '0, 0, 0, 0);
        load_bank(vals, 0);
        step(0, '0, 0, 0, 1);
        n_cmp += 2;
        if (swap !== 1'b1) begin n_bad++; $display("FAIL async_swap: got %b want 1", swap); end
        for (int k = 0; k < N; k++)
            if (coeffs[k] !== vals[k]) begin n_bad++; $display("FAIL async_coeff_after[%0d]: got %0d want %0d", k, coeffs[k], vals[k]); end
    endtask

    task automatic test_random();
        bit v, l, a, t;
        for (int c = 0; c < 600; c++) begin
            v = $urandom_range(0, 9) < 7;
            l = (m_buf.size() == N-1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 11) == 0);
            a = $urandom_range(0, 24) == 0;
            t = $urandom_range(0, 3) == 0;
            step(v, NB'($urandom), l, a, t);
            n_cmp++;
            if ({ready, swap, armed, err} !== {m_ready, m_swap, m_armed, m_err})
                begin n_bad++; $display("FAIL rand_flags cyc %0d: got rdy/swp/arm/err=%b want %b", c, {ready, swap, armed, err}, {m_ready, m_swap, m_armed, m_err}); end
            for (int k = 0; k < N; k++) begin
                n_cmp++;
                if (coeffs[k] !== m_active[k]) begin n_bad++; $display("FAIL rand_coeff[%0d] cyc %0d: got %0d want %0d", k, c, coeffs[k], m_active[k]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_golden_load();
        test_short_load();
        test_abort_armed();
        test_tick_with_last();
        test_backpressure();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, want completion");
        $fatal(1, "timeout");
    end
endmodule
